// File: rtl/logic_unit_seq_if.sv
// Handshake/bus bundle for the multi-cycle bitwise logic unit.
// The requester drives start/op/a/b; the unit returns busy/done/res/zero.
interface logic_unit_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res;
  logic             zero;

  modport master (output start, op, a, b, input  busy, done, res, zero);
  modport slave  (input  start, op, a, b, output busy, done, res, zero);
endinterface

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: AND/OR/XOR/NOR over WIDTH bits, one
// SLICE-bit slice per RUN cycle. Operands are latched on an accepted start;
// res/zero stay stable until the next accepted start.
module logic_unit_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic           clk,
  input  logic           rst,
  logic_unit_seq_if.slave bus
);
  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [N-1:0][SLICE-1:0]    a_q, b_q;
  logic [1:0]                 op_q;
  logic [N-1:0][SLICE-1:0]    res_q, res_d;
  logic                       zero_q, zero_d;
  logic                       accept;
  logic                       last;

  // One slice of the selected bitwise function; NOR is complemented per slice.
  function automatic logic [SLICE-1:0] slice_op(input logic [1:0]       op,
                                                input logic [SLICE-1:0] x,
                                                input logic [SLICE-1:0] y);
    case (op)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  // Next-state, slice write and zero-flag decode; an accept overrides RUN updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    zero_d  = zero_q;
    accept  = bus.start && (state_q == IDLE || state_q == DONE);
    last    = (cnt_q == CW'(N - 1));
    case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN: begin
        res_d[cnt_q] = slice_op(op_q, a_q[cnt_q], b_q[cnt_q]);
        cnt_d        = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          // zero must see the slice being written this edge
          zero_d  = (res_d == '0);
        end
      end
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      res_d  = '0;
      zero_d = 1'b0;
      cnt_d  = '0;
    end
  end

  // Control and result registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  // Operand/op capture, only on an accepted start so later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= 2'b00;
    end else if (accept) begin
      a_q  <= bus.a;
      b_q  <= bus.b;
      op_q <= bus.op;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.res  = res_q;
  assign bus.zero = zero_q;
endmodule

// File: doc/logic_unit_seq.md
# logic_unit_seq

Parametrised multi-cycle bitwise logic unit for the ALU datapath. It computes AND, OR, XOR or NOR of two WIDTH-bit operands one SLICE-bit slice per clock, so area can be traded against latency. Operands are captured on a start/busy/done handshake. The result and a zero flag are held stable until the next operation is accepted.

## Interface
- WIDTH, 32: operand and result width in bits.
- SLICE, 8: bits processed per RUN cycle. Must divide WIDTH evenly and satisfy 1 ≤ SLICE ≤ WIDTH.
- N (localparam) = WIDTH/SLICE: number of RUN cycles.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a new operation; sampled on each rising edge.
- op  in  2  operation code: 00 AND, 01 OR, 10 XOR, 11 NOR.
- a  in  WIDTH  operand A; sampled only on an accepted start.
- b  in  WIDTH  operand B; sampled only on an accepted start.
- busy  out  1  high while in RUN.
- done  out  1  high for exactly one cycle in DONE.
- res  out  WIDTH  result register.
- zero  out  1  high when the completed res is all zeros.

## Operation
- FSM states: IDLE, RUN, DONE.
- Start acceptance: start=1 in IDLE or DONE is accepted. On that edge:
  - latch a, b, op into internal registers;
  - clear res to 0 and zero to 0;
  - set slice counter cnt to 0;
  - go to RUN.
- start in RUN is ignored. The latched operands and op are unaffected, and there is no queueing.
- RUN, each edge:
  - res[cnt*SLICE +: SLICE] <= f(op_l, a_l slice, b_l slice); cnt increments.
  - When cnt==N-1, the edge writes the last slice, loads zero from the complete final result (including the slice being written) and goes to DONE.
- DONE:
  - lasts one cycle;
  - next state is RUN if start=1, otherwise IDLE.
- res and zero hold their value in IDLE and DONE until the next accepted start.
- Changing a, b or op after acceptance has no effect on the operation in progress.
- cnt width is max(1, clog2(N)). No wrap-around: cnt is only compared against N-1 and is reset on acceptance.
- Degenerate case N=1 (SLICE==WIDTH): RUN lasts exactly one cycle.
- NOR is the bitwise complement of OR, applied per slice.

## Timing
- Reset (asynchronous, any time, including mid-RUN):
  - immediately: state=IDLE, cnt=0, res=0, zero=0, busy=0, done=0;
  - the in-flight operation is discarded;
  - after reset deasserts, the first rising edge with start=1 is accepted.
- Accept at edge E:
  - busy=1 from E until edge E+N;
  - slices 0..N-1 written at edges E+1..E+N;
  - done=1 and res/zero final between edges E+N and E+N+1.
- Latency: N+1 edges from accept to the done-cycle end. Back-to-back throughput is one result per N+1 cycles.
- During RUN, res shows partial results: completed slices hold their values and the rest are 0.
- Outputs busy and done are decoded directly from state registers, with no combinational path from inputs.

## Test plan
- Reset during operation.
  - Stimulus: reset=1 → all outputs 0.
  - Stimulus: with WIDTH=32, SLICE=8, start op=00, a=FFFF0000, b=0F0F0F0F.
  - Required: busy for 4 cycles, then done one cycle with res=0F0F0000, zero=0.
  - Stimulus: repeat the operation and assert reset at its 2nd RUN cycle.
  - Required: res=0 and busy=0 immediately, and done never pulses.
- All ops, a=12345678, b=0000FFFF.
  - op=01 → 1234FFFF.
  - op=10 → 1234A987.
  - op=11 → EDCB0000.
- Zero flag.
  - Stimulus: op=00, a=AAAAAAAA, b=55555555.
  - Required: res=00000000, zero=1 in the done cycle; zero holds 1 in IDLE until the next accept, then clears.
- Ignored start and held inputs.
  - Stimulus: pulse start with different operands mid-RUN, and change a and b every cycle after acceptance.
  - Required: the result matches the originally latched operands and op; the RUN length is unchanged.
- Back-to-back.
  - Stimulus: start held high continuously.
  - Required: done pulses every 5 cycles, busy is low only in DONE cycles, and each res matches the operands present at its accept edge.
- Parameter sweep.
  - Stimulus: SLICE ∈ {1, 4, 32} with random operands and ops versus a reference model.
  - Required: done at edge E+N for N = 32, 8 and 1 respectively.
  - Required: partial res during RUN shows exactly the completed low slices.
